// File: rtl/uart_pkg.sv
`default_nettype none
// =============================================================================
// uart_pkg : receiver state type and oversampling constants shared by uart_rx/tx
// Revision : 1.0
// =============================================================================
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// =============================================================================
// sync_2ff : two-stage synchronizer for one asynchronous bit, selectable reset value
// Revision : 1.0
// =============================================================================
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// =============================================================================
// uart_rx  : 16x-oversampling UART receiver, LSB first, one-cycle done pulse
// Revision : 1.0
// =============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int SB_TICK   = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 s_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done_tick,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  // Tick counter must also reach SB_TICK-1 while sampling the stop bit(s)
  localparam int c_SCNT_W = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : $clog2(OVERSAMPLE);
  localparam logic [c_SCNT_W-1:0] c_MID_TICK  = c_SCNT_W'(MID_SAMPLE);
  localparam logic [c_SCNT_W-1:0] c_LAST_TICK = c_SCNT_W'(OVERSAMPLE - 1);
  localparam logic [c_SCNT_W-1:0] c_STOP_TICK = c_SCNT_W'(SB_TICK - 1);
  localparam logic [2:0]          c_LAST_BIT  = 3'(DATA_BITS - 1);

  uart_rx_state_t        r_state;
  logic [c_SCNT_W-1:0]   r_s_cnt;
  logic [2:0]            r_n_cnt;
  logic [DATA_BITS-1:0]  r_b;
  logic                  r_rx_prev;
  logic                  w_rx_sync;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (rx),
    .o_q     (w_rx_sync)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_s_cnt      <= '0;
      r_n_cnt      <= '0;
      r_b          <= '0;
      r_rx_prev    <= 1'b1;
      rx_data      <= '0;
      rx_done_tick <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      r_rx_prev    <= w_rx_sync;
      rx_done_tick <= 1'b0;
      rx_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          // Edge-triggered start: a line stuck low never re-arms reception
          if (r_rx_prev && !w_rx_sync) begin
            r_state <= START;
            r_s_cnt <= '0;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (s_tick) begin
            if (r_s_cnt == c_MID_TICK) begin
              if (!w_rx_sync) begin
                r_state <= DATA;
                r_s_cnt <= '0;
                r_n_cnt <= '0;
              end else begin
                r_state <= IDLE;
                rx_busy <= 1'b0;
              end
            end else begin
              r_s_cnt <= r_s_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (r_s_cnt == c_LAST_TICK) begin
              r_s_cnt <= '0;
              r_b     <= {w_rx_sync, r_b[DATA_BITS-1:1]};
              if (r_n_cnt == c_LAST_BIT) begin
                r_state <= STOP;
              end else begin
                r_n_cnt <= r_n_cnt + 1'b1;
              end
            end else begin
              r_s_cnt <= r_s_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (r_s_cnt == c_STOP_TICK) begin
              r_state      <= IDLE;
              rx_busy      <= 1'b0;
              rx_data      <= r_b;
              rx_done_tick <= 1'b1;
              rx_frame_err <= ~w_rx_sync;
            end else begin
              r_s_cnt <= r_s_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// =============================================================================
// tb_uart_rx : frame-level model and per-cycle output check for two uart_rx configs
// Revision   : 1.0
// =============================================================================
module tb_uart_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       s_tick;
  logic       rx8, rx7;
  logic [7:0] rx_data8;
  logic       done8, err8, busy8;
  logic [6:0] rx_data7;
  logic       done7, err7, busy7;

  uart_rx #(.DATA_BITS(8), .SB_TICK(16)) dut8 (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_tick       (s_tick),
    .rx           (rx8),
    .rx_data      (rx_data8),
    .rx_done_tick (done8),
    .rx_frame_err (err8),
    .rx_busy      (busy8)
  );

  uart_rx #(.DATA_BITS(7), .SB_TICK(32)) dut7 (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_tick       (s_tick),
    .rx           (rx7),
    .rx_data      (rx_data7),
    .rx_done_tick (done7),
    .rx_frame_err (err7),
    .rx_busy      (busy7)
  );

  typedef struct {
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t       q8[$];
  exp_t       q7[$];
  exp_t       e8, e7;
  logic [7:0] held8 = '0;
  logic [6:0] held7 = '0;
  logic       last_err8 = 1'b0, last_err7 = 1'b1;
  logic       prev_done8 = 1'b0, prev_done7 = 1'b0;
  logic       rst_prev = 1'b0;
  logic       chk_en = 1'b0;
  int         done_cnt8 = 0, done_cnt7 = 0;
  int         n_cmp = 0, n_fail = 0;
  int         tick_div = 4;
  int         tick_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // s_tick: one-clk pulse every tick_div clocks
  initial begin
    s_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick_cnt = (tick_cnt + 1) % tick_div;
      s_tick   = (tick_cnt == 0);
    end
  end

  // Model: each completed frame pops the next expected word; rx_data holds it until the next
  always @(negedge clk) begin
    if (rst_prev) begin
      held8      = '0;
      held7      = '0;
      prev_done8 = 1'b0;
      prev_done7 = 1'b0;
    end
    rst_prev = !reset_n;
    if (chk_en) begin
      if (done8) begin
        done_cnt8++;
        if (q8.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done8: got data %0h, expected no frame at %0t", rx_data8, $time);
        end else begin
          e8        = q8.pop_front();
          held8     = e8.data;
          last_err8 = err8;
          check("frame_err8", {31'd0, err8}, {31'd0, e8.err});
          check("busy_at_done8", {31'd0, busy8}, 32'd0);
        end
        check("done_width8", {31'd0, prev_done8}, 32'd0);
      end else begin
        check("err_without_done8", {31'd0, err8}, 32'd0);
      end
      check("rx_data8", {24'd0, rx_data8}, {24'd0, held8});
      prev_done8 = done8;

      if (done7) begin
        done_cnt7++;
        if (q7.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done7: got data %0h, expected no frame at %0t", rx_data7, $time);
        end else begin
          e7        = q7.pop_front();
          held7     = e7.data[6:0];
          last_err7 = err7;
          check("frame_err7", {31'd0, err7}, {31'd0, e7.err});
          check("busy_at_done7", {31'd0, busy7}, 32'd0);
        end
        check("done_width7", {31'd0, prev_done7}, 32'd0);
      end else begin
        check("err_without_done7", {31'd0, err7}, 32'd0);
      end
      check("rx_data7", {25'd0, rx_data7}, {25'd0, held7});
      prev_done7 = done7;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int line, input logic v);
    if (line == 7) rx7 = v;
    else           rx8 = v;
  endtask

  // Drives start, nbits LSB-first data bits and nstop stop bits of value stop_val
  task automatic send_frame(input int line, input logic [7:0] val, input int nbits,
                            input int nstop, input logic stop_val);
    int bc;
    bc = 16 * tick_div;
    set_line(line, 1'b0);
    wait_clk(bc);
    for (int i = 0; i < nbits; i++) begin
      set_line(line, val[i]);
      wait_clk(bc);
    end
    set_line(line, stop_val);
    wait_clk(bc * nstop);
  endtask

  initial begin
    reset_n = 1'b0;
    rx8     = 1'b1;
    rx7     = 1'b1;
    wait_clk(5);
    check("reset_rx_data8", {24'd0, rx_data8}, 32'd0);
    check("reset_done8", {31'd0, done8}, 32'd0);
    check("reset_err8", {31'd0, err8}, 32'd0);
    check("reset_busy8", {31'd0, busy8}, 32'd0);
    check("reset_rx_data7", {25'd0, rx_data7}, 32'd0);
    check("reset_busy7", {31'd0, busy7}, 32'd0);
    chk_en  = 1'b1;
    reset_n = 1'b1;
    wait_clk(20);

    // Single 0xA5 frame
    q8.push_back('{8'hA5, 1'b0});
    send_frame(8, 8'hA5, 8, 1, 1'b1);
    wait_clk(128);
    check("t1_done_count", done_cnt8, 1);
    check("t1_data", {24'd0, rx_data8}, 32'hA5);
    check("t1_queue_empty", q8.size(), 0);

    // Back-to-back 0x00 then 0xFF
    q8.push_back('{8'h00, 1'b0});
    q8.push_back('{8'hFF, 1'b0});
    send_frame(8, 8'h00, 8, 1, 1'b1);
    send_frame(8, 8'hFF, 8, 1, 1'b1);
    wait_clk(128);
    check("t2_done_count", done_cnt8, 3);
    check("t2_data", {24'd0, rx_data8}, 32'hFF);
    check("t2_queue_empty", q8.size(), 0);

    // 8-clk low glitch: start detected, rejected at mid-start
    rx8 = 1'b0;
    wait_clk(6);
    check("t3_busy_rises", {31'd0, busy8}, 32'd1);
    wait_clk(2);
    rx8 = 1'b1;
    wait_clk(56);
    check("t3_busy_falls", {31'd0, busy8}, 32'd0);
    check("t3_no_done", done_cnt8, 3);

    // 0x3C with a low stop bit, then a 1000-clk break
    q8.push_back('{8'h3C, 1'b1});
    send_frame(8, 8'h3C, 8, 1, 1'b0);
    wait_clk(1000);
    check("t4_done_count", done_cnt8, 4);
    check("t4_data", {24'd0, rx_data8}, 32'h3C);
    check("t4_frame_err", {31'd0, last_err8}, 32'd1);
    check("t4_busy_in_break", {31'd0, busy8}, 32'd0);
    rx8 = 1'b1;
    wait_clk(128);
    check("t4_queue_empty", q8.size(), 0);

    // Reset in the middle of 0x55's data bits, then a clean 0x81
    rx8 = 1'b0;
    wait_clk(64);
    for (int i = 0; i < 3; i++) begin
      rx8 = i[0] ? 1'b0 : 1'b1;
      wait_clk(64);
    end
    rx8 = 1'b0;
    wait_clk(32);
    reset_n = 1'b0;
    wait_clk(1);
    reset_n = 1'b1;
    rx8     = 1'b1;
    check("t5_data_cleared", {24'd0, rx_data8}, 32'd0);
    check("t5_busy_cleared", {31'd0, busy8}, 32'd0);
    wait_clk(256);
    q8.push_back('{8'h81, 1'b0});
    send_frame(8, 8'h81, 8, 1, 1'b1);
    wait_clk(128);
    check("t5_done_count", done_cnt8, 5);
    check("t5_data", {24'd0, rx_data8}, 32'h81);
    check("t5_queue_empty", q8.size(), 0);

    // s_tick on every clock
    tick_div = 1;
    wait_clk(40);
    q8.push_back('{8'hC3, 1'b0});
    send_frame(8, 8'hC3, 8, 1, 1'b1);
    wait_clk(64);
    check("t7_done_count", done_cnt8, 6);
    check("t7_data", {24'd0, rx_data8}, 32'hC3);
    tick_div = 4;
    wait_clk(40);

    // 7 data bits, 2 stop bits, random phase against s_tick
    for (int rep = 0; rep < 3; rep++) begin
      wait_clk($urandom_range(0, 3));
      q7.push_back('{8'h5A, 1'b0});
      send_frame(7, 8'h5A, 7, 1, 1'b1);
      check("t6_no_done_after_1_stop", done_cnt7, rep);
      wait_clk(128);
      check("t6_done_after_2_stop", done_cnt7, rep + 1);
      check("t6_data", {25'd0, rx_data7}, 32'h5A);
      check("t6_frame_err", {31'd0, last_err7}, 32'd0);
    end
    check("t6_queue_empty", q7.size(), 0);
    check("t6_dut8_quiet", done_cnt8, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
